uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter funnelling NUM_SRC AXI-stream byte sources into one UART
// transmitter stream; a grant lasts one packet or at most MAX_BEATS bytes.
module uart_tx_arbiter #(
   parameter int NUM_SRC   = 4,
   parameter int MAX_BEATS = 64,
   parameter int IDW       = $clog2(NUM_SRC)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NUM_SRC*8-1:0] s_axis_tdata_i,
   input  logic [NUM_SRC-1:0]   s_axis_tvalid_i,
   input  logic [NUM_SRC-1:0]   s_axis_tlast_i,
   output logic [NUM_SRC-1:0]   s_axis_tready_o,
   output logic [7:0]           m_axis_tdata_o,
   output logic                 m_axis_tvalid_o,
   input  logic                 m_axis_tready_i,
   output logic [IDW-1:0]       grant_id_o,
   output logic                 busy_o,
   output logic                 trunc_o
);

   typedef enum logic {IDLE, PASS} state_e;

   localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);

   state_e         state_q;
   logic [IDW-1:0] grant_q, grant_d, last_q;
   logic [15:0]    beat_q;
   logic           trunc_q;
   logic [7:0]     g_data;
   logic           g_valid, g_last, hs;

   // Round-robin pick: lowest requester above last_q, otherwise the lowest
   // requester overall (the wrap-around case, which also covers last_q itself).
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      grant_d = last_q;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (s_axis_tvalid_i[k]) grant_d = IDW'(k);
      end
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (s_axis_tvalid_i[k] && (IDW'(k) > last_q)) grant_d = IDW'(k);
      end
   end

   always_comb begin
      g_data          = 8'h00;
      g_valid         = 1'b0;
      g_last          = 1'b0;
      s_axis_tready_o = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (grant_q == IDW'(k)) begin
            g_data             = s_axis_tdata_i[8*k +: 8];
            g_valid            = s_axis_tvalid_i[k];
            g_last             = s_axis_tlast_i[k];
            s_axis_tready_o[k] = (state_q == PASS) & m_axis_tready_i;
         end
      end
   end

   assign busy_o          = (state_q == PASS);
   assign m_axis_tvalid_o = busy_o & g_valid;
   assign m_axis_tdata_o  = busy_o ? g_data : 8'h00;
   assign hs              = m_axis_tvalid_o & m_axis_tready_i;
   assign grant_id_o      = grant_q;
   assign trunc_o         = trunc_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDW'(NUM_SRC - 1);
         beat_q  <= '0;
         trunc_q <= 1'b0;
      end else begin
         trunc_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|s_axis_tvalid_i) begin
                  grant_q <= grant_d;
                  state_q <= PASS;
               end
            end
            PASS: begin
               if (hs) begin
                  if (g_last || (beat_q == LAST_BEAT)) begin
                     state_q <= IDLE;
                     last_q  <= grant_q;
                     beat_q  <= '0;
                     trunc_q <= ~g_last;
                  end else begin
                     beat_q <= beat_q + 16'd1;
                  end
               end
            end
         endcase
      end
   end

endmodule
